// File: rtl/command_parser.sv
// Command FIFO read side: reassembles TILE/VERTEX/TRIANGLE/NOP byte commands and
// emits tile starts and resolved triangles over valid/ready handshakes.
module command_parser #(
  parameter int TILE_X_MAX = 9,
  parameter int TILE_Y_MAX = 7,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           command_rddata,
  input  logic                 command_empty,
  output logic                 command_pop,
  output logic                 tile_valid,
  input  logic                 tile_ready,
  output logic [3:0]           tile_x,
  output logic [2:0]           tile_y,
  output logic                 tri_valid,
  input  logic                 tri_ready,
  output logic [37:0]          tri_v0,
  output logic [37:0]          tri_v1,
  output logic [37:0]          tri_v2,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    ST_HDR       = 3'd0,
    ST_TILE_LO   = 3'd1,
    ST_VTX_BODY  = 3'd2,
    ST_EMIT_TILE = 3'd3,
    ST_EMIT_TRI  = 3'd4
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_TILE = 2'b01;
  localparam logic [1:0] OP_TRI = 2'b10;
  localparam logic [1:0] OP_VTX = 2'b11;

  // Range check done at 32 bits so the limit may equal the field's full range.
  function automatic logic id_in_range(input logic [31:0] id, input logic [31:0] max_id);
    id_in_range = (id <= max_id);
  endfunction

  state_t        state_r;
  state_t        next_state_s;
  logic [2:0]    byte_cnt_r;
  logic [1:0]    vtx_slot_r;
  logic [31:0]   vtx_shift_r;
  logic [37:0]   slot_mem_r [4];
  logic [3:0]    slot_valid_r;
  logic [3:0]    tile_x_r;
  logic [2:0]    tile_y_r;
  logic [37:0]   tri_v0_r;
  logic [37:0]   tri_v1_r;
  logic [37:0]   tri_v2_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  logic          pop_s;
  logic [1:0]    op_s;
  logic [1:0]    slot_a_s;
  logic [1:0]    slot_b_s;
  logic [1:0]    slot_c_s;
  logic          tri_ok_s;
  logic          tile_ok_s;
  logic          err_s;
  logic          vtx_last_s;
  logic [37:0]   vtx_word_s;

  assign op_s       = command_rddata[7:6];
  assign slot_a_s   = command_rddata[5:4];
  assign slot_b_s   = command_rddata[3:2];
  assign slot_c_s   = command_rddata[1:0];
  assign tri_ok_s   = slot_valid_r[slot_a_s] && slot_valid_r[slot_b_s] && slot_valid_r[slot_c_s];
  assign tile_ok_s  = id_in_range({28'd0, command_rddata[3:0]}, 32'(TILE_X_MAX)) &&
                      id_in_range({29'd0, command_rddata[6:4]}, 32'(TILE_Y_MAX));
  assign vtx_last_s = (byte_cnt_r == 3'd5);
  assign vtx_word_s = {vtx_shift_r[29:0], command_rddata};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; only popped bytes advance the parse.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (pop_s) begin
          case (op_s)
            OP_TILE: next_state_s = ST_TILE_LO;
            OP_VTX:  next_state_s = ST_VTX_BODY;
            OP_TRI:  next_state_s = tri_ok_s ? ST_EMIT_TRI : ST_HDR;
            OP_NOP:  next_state_s = ST_HDR;
            default: next_state_s = ST_HDR;
          endcase
        end else begin
          next_state_s = ST_HDR;
        end
      end
      ST_TILE_LO: begin
        if (pop_s) begin
          next_state_s = tile_ok_s ? ST_EMIT_TILE : ST_HDR;
        end else begin
          next_state_s = ST_TILE_LO;
        end
      end
      ST_VTX_BODY: begin
        if (pop_s && vtx_last_s) begin
          next_state_s = ST_HDR;
        end else begin
          next_state_s = ST_VTX_BODY;
        end
      end
      ST_EMIT_TILE: next_state_s = tile_ready ? ST_HDR : ST_EMIT_TILE;
      ST_EMIT_TRI:  next_state_s = tri_ready ? ST_HDR : ST_EMIT_TRI;
      default:      next_state_s = ST_HDR;
    endcase
  end

  // Output decode from the state register; pop stalls while an emit is pending.
  always_comb begin
    pop_s      = 1'b0;
    tile_valid = 1'b0;
    tri_valid  = 1'b0;
    case (state_r)
      ST_HDR, ST_TILE_LO, ST_VTX_BODY: pop_s = !command_empty;
      ST_EMIT_TILE: tile_valid = 1'b1;
      ST_EMIT_TRI:  tri_valid = 1'b1;
      default: begin
        pop_s      = 1'b0;
        tile_valid = 1'b0;
        tri_valid  = 1'b0;
      end
    endcase
  end

  // Protocol-error strobe: unresolved triangle slot or out-of-range tile id.
  always_comb begin
    err_s = 1'b0;
    if (pop_s && (state_r == ST_HDR) && (op_s == OP_TRI) && !tri_ok_s) begin
      err_s = 1'b1;
    end else if (pop_s && (state_r == ST_TILE_LO) && !tile_ok_s) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Datapath: vertex assembly, slot buffer, tile and triangle output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_r   <= 3'd0;
      vtx_slot_r   <= 2'd0;
      vtx_shift_r  <= 32'd0;
      slot_valid_r <= 4'd0;
      tile_x_r     <= 4'd0;
      tile_y_r     <= 3'd0;
      tri_v0_r     <= 38'd0;
      tri_v1_r     <= 38'd0;
      tri_v2_r     <= 38'd0;
      for (int i = 0; i < 4; i++) begin
        slot_mem_r[i] <= 38'd0;
      end
    end else if (pop_s) begin
      case (state_r)
        ST_HDR: begin
          if (op_s == OP_VTX) begin
            byte_cnt_r  <= 3'd1;
            vtx_slot_r  <= command_rddata[5:4];
            vtx_shift_r <= 32'd0;
          end else if ((op_s == OP_TRI) && tri_ok_s) begin
            tri_v0_r <= slot_mem_r[slot_a_s];
            tri_v1_r <= slot_mem_r[slot_b_s];
            tri_v2_r <= slot_mem_r[slot_c_s];
          end
        end
        ST_TILE_LO: begin
          if (tile_ok_s) begin
            tile_x_r     <= command_rddata[3:0];
            tile_y_r     <= command_rddata[6:4];
            slot_valid_r <= 4'd0;
          end
        end
        ST_VTX_BODY: begin
          vtx_shift_r <= {vtx_shift_r[23:0], command_rddata};
          if (vtx_last_s) begin
            byte_cnt_r               <= 3'd0;
            slot_mem_r[vtx_slot_r]   <= vtx_word_s;
            slot_valid_r[vtx_slot_r] <= 1'b1;
          end else begin
            byte_cnt_r <= byte_cnt_r + 3'd1;
          end
        end
        default: byte_cnt_r <= byte_cnt_r;
      endcase
    end
  end

  // Saturating protocol-error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_r <= '0;
    end else if (err_s && (err_count_r != {ERR_CNT_W{1'b1}})) begin
      err_count_r <= err_count_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign command_pop = pop_s;
  assign tile_x      = tile_x_r;
  assign tile_y      = tile_y_r;
  assign tri_v0      = tri_v0_r;
  assign tri_v1      = tri_v1_r;
  assign tri_v2      = tri_v2_r;
  assign err_count   = err_count_r;

endmodule

// File: tb/tb_command_parser.sv
// Directed bench for command_parser: a table of commands with hand-computed
// results plus hand-written sequences for stalls, resets and saturation.
module tb_command_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  command_rddata;
  logic        command_empty;
  logic        command_pop;
  logic        tile_valid;
  logic        tile_ready;
  logic [3:0]  tile_x;
  logic [2:0]  tile_y;
  logic        tri_valid;
  logic        tri_ready;
  logic [37:0] tri_v0;
  logic [37:0] tri_v1;
  logic [37:0] tri_v2;
  logic [7:0]  err_count;

  command_parser dut (
    .clk(clk), .rst(rst),
    .command_rddata(command_rddata), .command_empty(command_empty), .command_pop(command_pop),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_x(tile_x), .tile_y(tile_y),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vertex A = bytes 14 14 0F F8 00; vertex B = bytes FF 80 40 12 34.
  localparam logic [37:0] VA = {6'h14, 6'h05, 10'h00F, 16'hF800};
  localparam logic [37:0] VB = 38'h3F80401234;

  typedef struct {
    logic [47:0] bytes;
    int          n;
    logic        exp_tile;
    logic        exp_tri;
    logic [3:0]  x;
    logic [2:0]  y;
    logic [37:0] v0;
    logic [37:0] v1;
    logic [37:0] v2;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [16];
  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte at a negedge and return at the negedge after it is popped.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    command_rddata = b;
    command_empty = 1'b0;
    #1;
    while (!command_pop && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("pop_timeout", 64'(command_pop), 64'd1);
    @(negedge clk);
    command_empty = 1'b1;
  endtask

  task automatic handshake();
    tile_ready = 1'b1;
    tri_ready = 1'b1;
    @(negedge clk);
    tile_ready = 1'b0;
    tri_ready = 1'b0;
    chk("valid_drop", 64'({tile_valid, tri_valid}), 64'd0);
  endtask

  initial begin
    logic [47:0] bb;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    command_empty = 1'b1;
    command_rddata = 8'h00;
    tile_ready = 1'b0;
    tri_ready = 1'b0;

    vecs[0]  = '{48'h4023_0000_0000, 2, 1'b1, 1'b0, 4'd3, 3'd2, 38'd0, 38'd0, 38'd0, 8'd0};
    vecs[1]  = '{48'h4000_0000_0000, 2, 1'b1, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd0};
    vecs[2]  = '{48'h8600_0000_0000, 1, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd1};
    vecs[3]  = '{48'hC014_140F_F800, 6, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd1};
    vecs[4]  = '{48'hD014_140F_F800, 6, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd1};
    vecs[5]  = '{48'hE014_140F_F800, 6, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd1};
    vecs[6]  = '{48'h8600_0000_0000, 1, 1'b0, 1'b1, 4'd0, 3'd0, VA, VA, VA, 8'd1};
    vecs[7]  = '{48'h400A_0000_0000, 2, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd2};
    vecs[8]  = '{48'h8600_0000_0000, 1, 1'b0, 1'b1, 4'd0, 3'd0, VA, VA, VA, 8'd2};
    vecs[9]  = '{48'hD3FF_8040_1234, 6, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd2};
    vecs[10] = '{48'h9800_0000_0000, 1, 1'b0, 1'b1, 4'd0, 3'd0, VB, VA, VA, 8'd2};
    vecs[11] = '{48'h0000_0000_0000, 1, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd2};
    vecs[12] = '{48'h9F00_0000_0000, 1, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd3};
    vecs[13] = '{48'h7FF7_0000_0000, 2, 1'b1, 1'b0, 4'd7, 3'd7, 38'd0, 38'd0, 38'd0, 8'd3};
    vecs[14] = '{48'h4009_0000_0000, 2, 1'b1, 1'b0, 4'd9, 3'd0, 38'd0, 38'd0, 38'd0, 8'd3};
    vecs[15] = '{48'h8600_0000_0000, 1, 1'b0, 1'b0, 4'd0, 3'd0, 38'd0, 38'd0, 38'd0, 8'd4};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", 64'({command_pop, tile_valid, tri_valid, tile_x, tile_y, err_count}), 64'd0);
    chk("rst_tri_v", 64'(tri_v0 | tri_v1 | tri_v2), 64'd0);

    // Tile held for 5 cycles with data waiting: no pops, outputs stable.
    send_byte(8'h40);
    send_byte(8'h23);
    chk("hold_first", 64'({tile_valid, tile_x, tile_y}), 64'({1'b1, 4'd3, 3'd2}));
    command_rddata = 8'h00;
    command_empty = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_no_pop", 64'(command_pop), 64'd0);
      chk("hold_stable", 64'({tile_valid, tile_x, tile_y}), 64'({1'b1, 4'd3, 3'd2}));
    end
    handshake();
    command_empty = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bb = vecs[i].bytes;
      for (int j = 0; j < vecs[i].n; j++) begin
        send_byte(bb[47-8*j -: 8]);
      end
      chk($sformatf("v%0d_tile_valid", i), 64'(tile_valid), 64'(vecs[i].exp_tile));
      chk($sformatf("v%0d_tri_valid", i), 64'(tri_valid), 64'(vecs[i].exp_tri));
      chk($sformatf("v%0d_err", i), 64'(err_count), 64'(vecs[i].err));
      if (vecs[i].exp_tile) begin
        chk($sformatf("v%0d_tile_xy", i), 64'({tile_x, tile_y}), 64'({vecs[i].x, vecs[i].y}));
      end
      if (vecs[i].exp_tri) begin
        chk($sformatf("v%0d_v0", i), 64'(tri_v0), 64'(vecs[i].v0));
        chk($sformatf("v%0d_v1", i), 64'(tri_v1), 64'(vecs[i].v1));
        chk($sformatf("v%0d_v2", i), 64'(tri_v2), 64'(vecs[i].v2));
      end
      if (tile_valid || tri_valid) begin
        handshake();
      end
    end

    // Vertex into slot 0 with the FIFO empty between every byte.
    bb = 48'hC014_140F_F800;
    for (int j = 0; j < 6; j++) begin
      send_byte(bb[47-8*j -: 8]);
      #1;
      chk("gap_no_pop", 64'(command_pop), 64'd0);
      @(negedge clk);
    end
    bb = 48'hD014_140F_F800;
    for (int j = 0; j < 6; j++) send_byte(bb[47-8*j -: 8]);
    bb = 48'hE014_140F_F800;
    for (int j = 0; j < 6; j++) send_byte(bb[47-8*j -: 8]);
    send_byte(8'h86);
    chk("gap_tri", 64'({tri_valid, err_count}), 64'({1'b1, 8'd4}));
    chk("gap_v0", 64'(tri_v0), 64'(VA));
    handshake();

    // Reset in the middle of a vertex.
    send_byte(8'hC0);
    send_byte(8'h14);
    send_byte(8'h14);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 64'({tile_valid, tri_valid, tile_x, tile_y, err_count}), 64'd0);
    chk("midrst_tri_v", 64'(tri_v0 | tri_v1 | tri_v2), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h86);
    chk("postrst_tri", 64'({tri_valid, err_count}), 64'({1'b0, 8'd1}));

    // Error counter saturation.
    for (int k = 0; k < 254; k++) send_byte(8'h86);
    chk("err_at_max", 64'(err_count), 64'd255);
    for (int k = 0; k < 3; k++) send_byte(8'h86);
    chk("err_saturated", 64'(err_count), 64'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
